// File: rtl/p3_pkg.sv
// Shared encodings for the SIMPLE execute stage: ALU opcodes, branch conditions,
// memory access codes, flag bit positions and the stage state enum.
package p3_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_CMP  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_MOV  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SLR  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LDST = 4'd11,
      ALU_LI   = 4'd12,
      ALU_BR   = 4'd13,
      ALU_HLT  = 4'd14
   } aluOp_t;

   typedef enum logic [2:0] {
      BR_NONE   = 3'b000,
      BR_ALWAYS = 3'b001,
      BR_EQ     = 3'b010,
      BR_LT     = 3'b011,
      BR_LE     = 3'b100,
      BR_NE     = 3'b101
   } branchCond_t;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } memOp_t;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   // Bit positions inside the {S,Z,C,V} flag vector.
   localparam int unsigned FLAG_S = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/p3_execute_alu.sv
// Combinational ALU/shifter for the execute stage: produces the result and the
// SZCV candidate that the stage may commit to its flag register.
module p3_alu
   import p3_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  aluOp_t           aluOp,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic [WIDTH-1:0] imm,
   input  logic [3:0]       shiftAmt,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flagsOut
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] shl;
   logic [2*WIDTH-1:0] shr;
   logic [2*WIDTH-1:0] sra;
   logic [2*WIDTH-1:0] rol;
   logic               carry;
   logic               overflow;

   always_comb begin
      sum  = {1'b0, operandA} + {1'b0, operandB};
      diff = {1'b0, operandB} - {1'b0, operandA};
      // Shifts run in a double-width window so the last bit shifted out lands
      // at a fixed position next to the result (and is 0 when d = 0).
      shl  = {{WIDTH{1'b0}}, operandB} << shiftAmt;
      shr  = {operandB, {WIDTH{1'b0}}} >> shiftAmt;
      sra  = $signed({operandB, {WIDTH{1'b0}}}) >>> shiftAmt;
      rol  = {operandB, operandB} << shiftAmt;

      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (aluOp)
         ALU_ADD: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                       (sum[WIDTH-1] != operandA[WIDTH-1]);
         end
         ALU_SUB, ALU_CMP: begin
            result   = diff[WIDTH-1:0];
            carry    = diff[WIDTH];
            overflow = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                       (diff[WIDTH-1] != operandB[WIDTH-1]);
         end
         ALU_AND:  result = operandA & operandB;
         ALU_OR:   result = operandA | operandB;
         ALU_XOR:  result = operandA ^ operandB;
         ALU_MOV:  result = operandA;
         ALU_SLL: begin
            result = shl[WIDTH-1:0];
            carry  = shl[WIDTH];
         end
         ALU_SLR: begin
            result = rol[2*WIDTH-1:WIDTH];
            carry  = (shiftAmt != 4'd0) && rol[WIDTH];
         end
         ALU_SRL: begin
            result = shr[2*WIDTH-1:WIDTH];
            carry  = shr[WIDTH-1];
         end
         ALU_SRA: begin
            result = sra[2*WIDTH-1:WIDTH];
            carry  = sra[WIDTH-1];
         end
         ALU_LDST: result = operandA + imm;
         ALU_LI:   result = imm;
         default:  result = '0;
      endcase

      flagsOut = {result[WIDTH-1], (result == '0), carry, overflow};
   end

endmodule

// File: rtl/p3_execute.sv
// Execute stage of the SIMPLE pipeline: ALU, branch resolution against SZCV,
// halt tracking, and the registered boundary to the memory stage.
module p3_execute
   import p3_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [3:0]       aluOp,
   input  logic             setFlags,
   input  logic [2:0]       branchCond,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic [WIDTH-1:0] imm,
   input  logic [3:0]       shiftAmt,
   input  logic [WIDTH-1:0] pcIn,
   input  logic [1:0]       memWriteIn,
   input  logic             writeRegIn,
   input  logic [2:0]       regAddressIn,
   output logic [WIDTH-1:0] address,
   output logic [WIDTH-1:0] storeData,
   output logic [1:0]       memWrite,
   output logic             writeReg,
   output logic [2:0]       regAddress,
   output logic             branchTaken,
   output logic [WIDTH-1:0] branchTarget,
   output logic [3:0]       flags,
   output logic             halted
);

   aluOp_t           op;
   state_t           state;
   state_t           stateNext;
   logic             issue;
   logic             condTrue;
   logic [WIDTH-1:0] aluResult;
   logic [3:0]       aluFlags;
   logic             lessThan;

   assign op = aluOp_t'(aluOp);

   p3_alu #(.WIDTH(WIDTH)) alu (
      .aluOp    (op),
      .operandA (operandA),
      .operandB (operandB),
      .imm      (imm),
      .shiftAmt (shiftAmt),
      .result   (aluResult),
      .flagsOut (aluFlags)
   );

   // Conditions read the committed flag register, i.e. the previous instruction's flags.
   always_comb begin
      lessThan = flags[FLAG_S] ^ flags[FLAG_V];
      condTrue = 1'b0;
      case (branchCond_t'(branchCond))
         BR_ALWAYS: condTrue = 1'b1;
         BR_EQ:     condTrue = flags[FLAG_Z];
         BR_LT:     condTrue = lessThan;
         BR_LE:     condTrue = flags[FLAG_Z] | lessThan;
         BR_NE:     condTrue = !flags[FLAG_Z];
         default:   condTrue = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= stateNext;
   end

   // HLT never issues: it only moves the FSM, so it leaves the stage as a bubble.
   always_comb begin
      stateNext = state;
      issue     = 1'b0;
      if (!flush && !stall && state == RUN && valid) begin
         if (op == ALU_HLT) stateNext = HALTED;
         else               issue     = 1'b1;
      end
   end

   assign halted = (state == HALTED);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         address      <= '0;
         storeData    <= '0;
         memWrite     <= MEM_NONE;
         writeReg     <= 1'b0;
         regAddress   <= '0;
         branchTaken  <= 1'b0;
         branchTarget <= '0;
         flags        <= '0;
      end else if (flush || (!stall && !issue)) begin
         memWrite    <= MEM_NONE;
         writeReg    <= 1'b0;
         branchTaken <= 1'b0;
      end else if (issue) begin
         address      <= aluResult;
         storeData    <= operandB;
         memWrite     <= memWriteIn;
         writeReg     <= writeRegIn && (op != ALU_CMP);
         regAddress   <= regAddressIn;
         branchTaken  <= condTrue;
         branchTarget <= pcIn + WIDTH'(1) + imm;
         if (setFlags) flags <= aluFlags;
      end
   end

endmodule

// File: doc/p3_execute.md
# p3_execute

Execute stage of the 16-bit SIMPLE pipeline. Sits between decode (p2) and the memory stage (p4). It performs the ALU or shift operation, computes load/store effective addresses, evaluates branch conditions against the SZCV flag register, and tracks halt state. All results go to p4 through one registered pipeline boundary.

## Interface
Parameters:
- `WIDTH`, 16, datapath width. Only 16 is supported.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid` in 1: decode presents an instruction this cycle.
- `stall` in 1: hold all output registers and the flag register.
- `flush` in 1: load a bubble into the output registers.
- `aluOp` in 4: operation code, encoded in package `p3_pkg`.
- `setFlags` in 1: instruction updates SZCV.
- `branchCond` in 3: 000 none, 001 B, 010 BE, 011 BLT, 100 BLE, 101 BNE.
- `operandA` in 16: Rs value, or base register for load/store.
- `operandB` in 16: Rd value, which is also the store data.
- `imm` in 16: sign-extended displacement or immediate.
- `shiftAmt` in 4: shift count d.
- `pcIn` in 16: PC of the instruction.
- `memWriteIn` in 2: 00 none, 01 read, 10 write.
- `writeRegIn` in 1: register writeback enable.
- `regAddressIn` in 3: destination register.
- `address` out 16: ALU result, or effective address (to p4).
- `storeData` out 16: registered `operandB`.
- `memWrite` out 2: registered `memWriteIn`.
- `writeReg` out 1: registered `writeRegIn`.
- `regAddress` out 3: registered `regAddressIn`.
- `branchTaken` out 1: one-cycle pulse.
- `branchTarget` out 16: pcIn+1+imm.
- `flags` out 4: {S,Z,C,V} register.
- `halted` out 1: HLT has retired through this stage.

## Operation
Results by `aluOp`:
- ADD: A+B.
- SUB and CMP: B−A.
- AND, OR, XOR: bitwise.
- MOV: A.
- SLL, SLR (rotate left), SRL, SRA: operate on B by d.
- LDST: A+imm.
- LI: imm.
- BR: no result; only the branch outputs are used.
- HLT: no result.
- For CMP, `writeRegIn` is ignored and `writeReg` is forced to 0.

Flags, written when `valid & setFlags & !stall & !flush` and the stage is in RUN:
- S = result[15]; Z = (result == 0).
- C = carry out for ADD; borrow (B < A unsigned) for SUB/CMP; last bit shifted out for shifts (0 when d = 0); 0 otherwise.
- V = signed overflow for ADD/SUB/CMP; 0 otherwise.

Branch:
- Condition is evaluated on the flag register as it stands this cycle, so the previous instruction's flags are used.
- BLT = S^V; BLE = Z|(S^V); BE = Z; BNE = !Z.
- `branchTaken` is registered alongside the other outputs.

State machine, two states:
- RUN, the reset state: a valid HLT moves the stage to HALTED.
- HALTED: `halted` = 1. Every input is converted to a bubble. Only `reset` exits this state.
- The HLT instruction itself passes as a bubble.

Bubble: `memWrite` = 00, `writeReg` = 0, `branchTaken` = 0. The other output registers hold their previous values.

## Timing
- Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- Reset value of every output and of the flag register is 0. The state resets to RUN.
- Per-edge priority: reset > flush > stall > valid.
  - flush: bubble, flags unchanged, state unchanged.
  - stall: all registers hold, including `branchTaken`. No flag update, no halt transition.
  - `valid` = 0: bubble.
- A flags-setting instruction followed directly by a branch: the branch sees the new flags, because the flags were written at the previous edge.
- Arithmetic wraps mod 2^16. Shift with d ≥ 16 is not encodable.
- Reset asserted mid-operation clears everything asynchronously. The first capture is at the first edge after reset deasserts.

## Structure
- `p3_pkg` holds the `aluOp` encodings, the `branchCond` encodings, the `memWrite` codes, and the state enum.
- Sub-module `p3_alu` is purely combinational and produces the result and the SZCV candidate. `p3_execute` holds the pipeline registers, the flag register, and the FSM.

## Test plan
1. ADD A=0x7FFF, B=0x0001, setFlags → `address` = 0x8000 one cycle later; flags S=1, Z=0, C=0, V=1.
2. CMP A=5, B=5, then BE imm=0x0010 at pcIn=0x0020 → `branchTaken` = 1, `branchTarget` = 0x0031, `writeReg` = 0 for the CMP.
3. LDST A=0x0100, imm=0xFFFE, memWriteIn=10, B=0xBEEF → `address` = 0x00FE, `storeData` = 0xBEEF, `memWrite` = 10.
4. SRA B=0x8001, d=1 → result 0xC000, C=1. SLL B=0x1234, d=0 → result 0x1234, C=0.
5. Issue ADD with stall held 2 cycles, then flush → outputs hold for 2 cycles, then `memWrite` = 00, `writeReg` = 0, and flags are unchanged.
6. HLT, then a valid ADD with writeRegIn=1 → `halted` = 1 and `writeReg` stays 0. Assert reset mid-cycle → all outputs go to 0 immediately.
